// File: rtl/stopwatch_mode_ctrl.sv
// Purpose : synchronize + debounce the raw push-button, classify presses as short/long, drive the stopwatch mode.
// Latency : btn_db follows the raw button after 2 sync + DEBOUNCE_CYCLES cycles; a short press acts 1 cycle after btn_db falls; a long press acts LONG_CYCLES cycles after btn_db rises.
// Backpr. : none; the mode is a held level and the events are single-cycle registered pulses, so there is nothing to stall.
//
// Ports:
//   i_clk           system clock, rising-edge active
//   i_rst           asynchronous active-high reset
//   i_button        raw asynchronous push-button, 1 = pressed
//   o_mode[2:0]     000 IDLE, 001 RUN, 010 PAUSE, 011 CLEAR
//   o_mode_chg      one-cycle pulse when o_mode takes a new value
//   o_short_pulse   one-cycle pulse per accepted short press
//   o_long_pulse    one-cycle pulse per accepted long press
//   o_btn_db        debounced button level
//
// DEBOUNCE_CYCLES and LONG_CYCLES must both be >= 2.
module stopwatch_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button,
  output logic [2:0] o_mode,
  output logic       o_mode_chg,
  output logic       o_short_pulse,
  output logic       o_long_pulse,
  output logic       o_btn_db
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'b000,
    MODE_RUN   = 3'b001,
    MODE_PAUSE = 3'b010,
    MODE_CLEAR = 3'b011
  } mode_e;

  // Synchronizer and debounce
  logic              r_s1;
  logic              r_s2;
  logic              r_btn_db;
  logic              r_db_prev;
  logic [DB_W-1:0]   r_db_cnt;

  // Press classification
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_fired;

  // Mode state and registered outputs
  mode_e             r_mode;
  mode_e             w_mode_nxt;
  logic              r_mode_chg;
  logic              r_short_pulse;
  logic              r_long_pulse;

  logic              w_long_evt;
  logic              w_short_evt;

  // ---------------------------------------------------------------------------
  // Synchronizer, debounce, hold counter and pulse registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_btn_db      <= 1'b0;
      r_db_prev     <= 1'b0;
      r_db_cnt      <= '0;
      r_hold_cnt    <= '0;
      r_long_fired  <= 1'b0;
      r_mode_chg    <= 1'b0;
      r_short_pulse <= 1'b0;
      r_long_pulse  <= 1'b0;
    end else begin
      r_s1 <= i_button;
      r_s2 <= r_s1;

      // Any single cycle of agreement restarts the count, so only an
      // uninterrupted run of DEBOUNCE_CYCLES mismatches moves btn_db.
      if (r_s2 != r_btn_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_ONE;
        end
      end else begin
        r_db_cnt <= '0;
      end

      r_db_prev <= r_btn_db;

      // The hold count follows the debounced level only, so short raw
      // bounces inside a press cannot restart it.
      if (!r_btn_db) begin
        r_hold_cnt   <= '0;
        r_long_fired <= 1'b0;
      end else begin
        if (r_hold_cnt != HOLD_SAT) begin
          r_hold_cnt <= r_hold_cnt + HOLD_ONE;
        end
        if (w_long_evt) begin
          r_long_fired <= 1'b1;
        end
      end

      r_short_pulse <= w_short_evt;
      r_long_pulse  <= w_long_evt;
      r_mode_chg    <= (w_mode_nxt != r_mode);
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= MODE_IDLE;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: event detection and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_long_evt  = 1'b0;
    w_short_evt = 1'b0;
    w_mode_nxt  = r_mode;

    // hold_cnt passes LONG_CYCLES-1 once per press; long_fired guards the
    // saturated tail and also silences the eventual release.
    w_long_evt  = r_btn_db && (r_hold_cnt == HOLD_FIRE) && !r_long_fired;
    w_short_evt = r_db_prev && !r_btn_db && !r_long_fired;

    if (w_long_evt) begin
      w_mode_nxt = MODE_CLEAR;
    end else if (w_short_evt) begin
      case (r_mode)
        MODE_IDLE:  w_mode_nxt = MODE_RUN;
        MODE_RUN:   w_mode_nxt = MODE_PAUSE;
        MODE_PAUSE: w_mode_nxt = MODE_RUN;
        MODE_CLEAR: w_mode_nxt = MODE_RUN;
        // An unreachable code recovers exactly as IDLE would.
        default:    w_mode_nxt = MODE_RUN;
      endcase
    end
  end

  assign o_mode        = r_mode;
  assign o_mode_chg    = r_mode_chg;
  assign o_short_pulse = r_short_pulse;
  assign o_long_pulse  = r_long_pulse;
  assign o_btn_db      = r_btn_db;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Bench for stopwatch_mode_ctrl with DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10.
// Stimulus is driven per clock edge; the reference model derives the
// expected debounced level, events and mode from the whole input history.
module tb_stopwatch_mode_ctrl;

  localparam int DB   = 4;
  localparam int LNG  = 10;
  localparam int MAXN = 4096;

  logic       clk;
  logic       rst;
  logic       button;
  logic [2:0] mode;
  logic       mode_chg;
  logic       short_pulse;
  logic       long_pulse;
  logic       btn_db;

  stopwatch_mode_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LNG)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_button      (button),
    .o_mode        (mode),
    .o_mode_chg    (mode_chg),
    .o_short_pulse (short_pulse),
    .o_long_pulse  (long_pulse),
    .o_btn_db      (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit s;
    bit l;
    bit chg;
    int md;
  } ev_t;

  typedef struct {
    bit db;
    int md;
  } lv_t;

  ev_t ev_q[$];
  lv_t lv_q[$];

  int n_pass  = 0;
  int n_total = 0;

  // History of inputs applied at each edge and the model's debounced level.
  bit b_arr  [MAXN];
  bit r_arr  [MAXN];
  bit db_arr [MAXN];
  int j_cur   = 0;
  int mdl_mode = 0;
  int short_next [4] = '{1, 2, 1, 1};

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Value s2 holds after edge m: the raw input two samples back, or 0 if
  // either of the two flops was held in reset.
  function automatic bit s2_after(input int m);
    if (m < 1) return 1'b0;
    if (r_arr[m] || r_arr[m-1]) return 1'b0;
    return b_arr[m-1];
  endfunction

  // Length of the run of debounced-high cycles ending at index k.
  function automatic int run_len(input int k);
    int n = 0;
    for (int i = k; i >= 0; i--) begin
      if (!db_arr[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int pack_ev(input int cyc, input bit s, input bit l,
                                 input bit chg, input int md);
    return (cyc << 8) | (int'(s) << 6) | (int'(l) << 5) | (int'(chg) << 4) | (md & 7);
  endfunction

  // Apply one edge worth of input, predict what the DUT must show after that
  // edge, and queue the prediction.
  task automatic step(input bit b, input bit r);
    int  j;
    bit  prev;
    bit  flip;
    bit  lng;
    bit  sht;
    int  nm;
    ev_t e;
    lv_t lv;
    j = j_cur;
    b_arr[j] = b;
    r_arr[j] = r;

    // Debounced level flips once the last DB synchronized samples all disagree.
    if (r) begin
      db_arr[j] = 1'b0;
    end else begin
      prev = (j > 0) ? db_arr[j-1] : 1'b0;
      flip = 1'b1;
      for (int i = 1; i <= DB; i++) begin
        if (j - i < 0 || s2_after(j - i) == prev) flip = 1'b0;
      end
      db_arr[j] = flip ? !prev : prev;
    end

    // Long: the press has been debounced-high for exactly LNG cycles.
    lng = !r && (j >= 1) && (run_len(j - 1) == LNG);
    // Short: a genuine (not reset) debounced fall of a press shorter than LNG.
    sht = !r && (j >= 2) && !r_arr[j-1] && !db_arr[j-1] && db_arr[j-2] &&
          (run_len(j - 2) < LNG);

    if (r) begin
      mdl_mode = 0;
    end else if (lng || sht) begin
      nm    = lng ? 3 : short_next[mdl_mode];
      e.cyc = j;
      e.s   = sht;
      e.l   = lng;
      e.chg = (nm != mdl_mode);
      e.md  = nm;
      ev_q.push_back(e);
      mdl_mode = nm;
    end

    lv.db = db_arr[j];
    lv.md = mdl_mode;
    lv_q.push_back(lv);

    button = b;
    rst    = r;
    @(negedge clk);
    j_cur++;
  endtask

  task automatic hold(input bit b, input bit r, input int n);
    for (int i = 0; i < n; i++) step(b, r);
  endtask

  // Monitor: levels every cycle, events whenever the DUT pulses.
  initial begin : monitor
    int  edge_n;
    lv_t lv;
    ev_t e;
    edge_n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (lv_q.size() > 0) begin
        lv = lv_q.pop_front();
        check("btn_db", int'(btn_db), int'(lv.db));
        check("mode", int'(mode), lv.md);
      end
      if (short_pulse || long_pulse || mode_chg) begin
        if (ev_q.size() == 0) begin
          check("unexpected_event", pack_ev(edge_n, short_pulse, long_pulse, mode_chg, int'(mode)), 0);
        end else begin
          e = ev_q.pop_front();
          check("event", pack_ev(edge_n, short_pulse, long_pulse, mode_chg, int'(mode)),
                pack_ev(e.cyc, e.s, e.l, e.chg, e.md));
        end
      end
      edge_n++;
    end
  end

  initial begin : driver
    int hi;
    int lo;
    button = 1'b0;
    rst    = 1'b1;

    // Reset with the button toggling, then quiet.
    for (int i = 0; i < 6; i++) step(1'($urandom_range(1, 0)), 1'b1);
    hold(0, 0, 5);

    // Glitch shorter than the debounce window.
    hold(1, 0, 3);
    hold(0, 0, 10);

    // Clean short press: IDLE -> RUN.
    hold(1, 0, 8);
    hold(0, 0, 12);

    // Two short presses with a 3-cycle bounce inside each: RUN -> PAUSE -> RUN.
    for (int k = 0; k < 2; k++) begin
      hold(1, 0, 4);
      hold(0, 0, 3);
      hold(1, 0, 1);
      hold(0, 0, 12);
    end

    // Long press, then a short press: -> CLEAR -> RUN.
    hold(1, 0, 25);
    hold(0, 0, 12);
    hold(1, 0, 6);
    hold(0, 0, 12);

    // Long press, then another long press while already in CLEAR.
    hold(1, 0, 25);
    hold(0, 0, 12);
    hold(1, 0, 25);
    hold(0, 0, 12);

    // Reset in the middle of a debounced press, button kept high.
    hold(1, 0, 10);
    hold(1, 1, 2);
    hold(1, 0, 20);
    hold(0, 0, 12);

    // Random presses, occasional bounces and resets.
    for (int k = 0; k < 40; k++) begin
      hi = $urandom_range(16, 1);
      if ($urandom_range(3, 0) == 0) begin
        hold(1, 0, hi);
        hold(0, 0, $urandom_range(3, 1));
        hold(1, 0, $urandom_range(8, 1));
      end else begin
        hold(1, 0, hi);
      end
      if ($urandom_range(9, 0) == 0) begin
        hold(1, 1, $urandom_range(2, 1));
        hold(1, 0, $urandom_range(14, 4));
      end
      lo = $urandom_range(14, 1);
      hold(0, 0, lo);
    end

    hold(0, 0, 30);
    repeat (3) @(negedge clk);
    check("leftover_events", ev_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
